// File: rtl/cla_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, each trial
// subtraction done through a ripple of 4-bit carry-lookahead groups.
module cla_restoring_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int SW = WIDTH + 4;
   localparam int NG = SW / 4;

   logic [1:0]       state_reg;
   logic [WIDTH:0]   a_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] d_reg;
   logic [CW-1:0]    count_reg;
   logic [WIDTH-1:0] quotient_reg;
   logic [WIDTH-1:0] remainder_reg;
   logic             dz_reg;
   logic             done_reg;

   logic [WIDTH:0]   a_shift;
   logic [SW-1:0]    cla_a;
   logic [SW-1:0]    cla_b;
   logic [SW:0]      carry;
   logic [SW-1:0]    sum;
   logic             unused_hi;

   assign a_shift  = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
   assign cla_a    = {3'b000, a_shift};
   assign cla_b    = ~{4'b0000, d_reg};
   assign carry[0] = 1'b1;

   // Each group resolves its carries from its own generate/propagate terms and
   // the group carry-in; groups ripple into each other.
   genvar gi;
   generate
      for (gi = 0; gi < NG; gi++) begin : g_cla
         logic [3:0] gg;
         logic [3:0] pp;
         logic       cin;
         assign gg  = cla_a[4*gi +: 4] & cla_b[4*gi +: 4];
         assign pp  = cla_a[4*gi +: 4] ^ cla_b[4*gi +: 4];
         assign cin = carry[4*gi];
         assign carry[4*gi+1] = gg[0] | (pp[0] & cin);
         assign carry[4*gi+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin);
         assign carry[4*gi+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                              | (pp[2] & pp[1] & pp[0] & cin);
         assign carry[4*gi+4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                              | (pp[3] & pp[2] & pp[1] & gg[0]) | (&pp & cin);
         assign sum[4*gi +: 4] = pp ^ carry[4*gi +: 4];
      end
   endgenerate

   // Partial remainder stays below the divisor, so its top bit and the
   // extension bits of the adder never carry information.
   assign unused_hi = ^{sum[SW-1:WIDTH+1], carry[SW], a_reg[WIDTH]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         a_reg         <= '0;
         q_reg         <= '0;
         d_reg         <= '0;
         count_reg     <= '0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         dz_reg        <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  q_reg         <= dividend;
                  d_reg         <= divisor;
                  a_reg         <= '0;
                  count_reg     <= '0;
                  quotient_reg  <= '0;
                  remainder_reg <= '0;
                  dz_reg        <= 1'b0;
                  state_reg     <= (divisor == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               // Sum MSB clear means the trial subtraction did not borrow.
               if (!sum[WIDTH]) begin
                  a_reg <= sum[WIDTH:0];
                  q_reg <= {q_reg[WIDTH-2:0], 1'b1};
               end else begin
                  a_reg <= a_shift;
                  q_reg <= {q_reg[WIDTH-2:0], 1'b0};
               end
               count_reg <= count_reg + CW'(1);
               if (count_reg == CW'(WIDTH - 1)) begin
                  state_reg <= DONE;
               end
            end
            DONE: begin
               done_reg <= 1'b1;
               if (d_reg == '0) begin
                  quotient_reg  <= '1;
                  remainder_reg <= q_reg;
                  dz_reg        <= 1'b1;
               end else begin
                  quotient_reg  <= q_reg;
                  remainder_reg <= a_reg[WIDTH-1:0];
               end
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy        = (state_reg != IDLE);
   assign done        = done_reg;
   assign quotient    = quotient_reg;
   assign remainder   = remainder_reg;
   assign div_by_zero = dz_reg;

endmodule

// File: doc/cla_restoring_divider.md
Name: cla_restoring_divider

Overview:
- Sequential unsigned restoring divider, the inverse of the datapath's multiply path.
- Produces quotient and remainder one bit per clock.
- Each trial subtraction uses a ripple of 4-bit carry-lookahead groups: divisor inverted, carry-in = 1.
- Sits beside the Vedic multiplier as the arithmetic unit's divide engine, with a start/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of 4 (CLA group size), legal range 4..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  unsigned dividend; captured when start is accepted.
- divisor  input  WIDTH  unsigned divisor; captured when start is accepted.
- busy  output  1  high in RUN and DONE states.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  WIDTH  result quotient; held until the next accepted start.
- remainder  output  WIDTH  result remainder; held until the next accepted start.
- div_by_zero  output  1  set with done when the captured divisor = 0; held until the next accepted start.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; busy = 0; done = 0.
  - quotient = 0; remainder = 0; div_by_zero = 0.
  - Internal registers and the iteration counter cleared.
  - Applies immediately and mid-operation; any division in progress is abandoned with no done pulse.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start = 1, capture dividend into the shift register Q, divisor into D, and clear partial remainder A (WIDTH+1 bits).
  - Clear quotient, remainder and div_by_zero.
  - If the captured divisor = 0, go to DONE; else go to RUN with count = 0.
  - start = 0: stay in IDLE.
- RUN, one iteration per cycle:
  - Shift {A,Q} left by 1.
  - T = A_shifted + ~{0,D} + 1, computed through CLA groups of width WIDTH+4 (zero-extended).
  - If T's MSB (bit WIDTH) = 0: A = T[WIDTH:0] and Q[0] = 1. Else keep A_shifted and Q[0] = 0.
  - count increments; after the iteration with count = WIDTH-1, go to DONE.
- DONE (exactly one cycle):
  - done = 1.
  - quotient = Q; remainder = A[WIDTH-1:0].
  - Divide-by-zero case: quotient = all ones, remainder = captured dividend, div_by_zero = 1.
  - Next state IDLE.
- Latency:
  - Start accepted at edge k -> done high during the cycle after edge k+WIDTH+1, i.e. WIDTH+1 cycles after acceptance.
  - Divide-by-zero: done high in the cycle after edge k+1.
- start while busy is ignored; operands are not re-sampled.
- start high in the DONE cycle is also ignored.
- start held high continuously: a new division is accepted in the first IDLE cycle after DONE (back-to-back throughput = WIDTH+2 cycles).
- Input operands may change freely after acceptance without affecting the result.
- Arithmetic invariant for all non-zero divisors:
  - dividend = quotient*divisor + remainder.
  - remainder < divisor.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8; start with 100 / 7 -> done 9 cycles after acceptance; quotient=14, remainder=2, div_by_zero=0; busy high for exactly 9 cycles.
- 255 / 1 -> quotient=255, remainder=0; then 5 / 9 -> quotient=0, remainder=5; then 255 / 255 -> quotient=1, remainder=0.
- 200 / 0 -> done 1 cycle after acceptance; quotient=255, remainder=200, div_by_zero=1; next 200 / 3 clears the flag, giving quotient=66, remainder=2.
- Start 100 / 7, pulse start with 9 / 3 at cycle 4 -> second request ignored; result quotient=14, remainder=2; exactly one done pulse.
- Assert rst_n=0 at cycle 5 of 100 / 7 -> outputs 0 immediately, no done pulse; after release, 50 / 6 -> quotient=8, remainder=2.
- Random sweep, 2000 operand pairs with start held high -> every result meets the invariant; done pulses spaced exactly 10 cycles apart.
